bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Parametrised BCD time counter in M..M:SS format, successor to the fixed 1-digit-minute counter.
- Adds configurable minute-digit count, up/down direction, parallel BCD load, wrap or saturate mode, and rollover/done status.
- Sits between the control FSM (enable, step, load) and the 7-segment display driver, which consumes PresentTime directly.

Parameters:
- MIN_DIGITS, 1: number of BCD minute digits (1..3). Max time is (10^MIN_DIGITS - 1):59.
- WRAP_MODE, 1: 1 wraps modulo at the limits; 0 saturates at the limit and enters DONE.
- TW, 4*(MIN_DIGITS+2): derived; do not override. Width of the time bus.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- CounterEnable  in  1  when high, apply one step per clock.
- CounterInput  in  4  step size in seconds, binary 0..15.
- CountDown  in  1  0 = count up, 1 = count down.
- Load  in  1  load LoadTime on this edge.
- LoadTime  in  TW  BCD time to load. Layout [TW-1:8] minutes, [7:4] tens of seconds, [3:0] seconds.
- PresentTime  out  TW  current BCD time, same layout as LoadTime.
- Rollover  out  1  one-cycle pulse on a wrap in either direction.
- Done  out  1  high while in the DONE state.
- LoadErr  out  1  one-cycle pulse when a Load is rejected.

Behaviour:
- All outputs are registered. An edge that updates the count makes the new value visible after that edge (1-cycle latency).
- Reset sets PresentTime=0, Rollover=0, Done=0, LoadErr=0 and state RUN. Reset overrides Load and Enable on the same edge, including in the middle of a count.
- Priority on each edge: Reset > Load > CounterEnable.
- Load validation:
  - Valid if every minute digit <=9, the tens-of-seconds digit <=5 and the seconds digit <=9.
  - Valid load: PresentTime=LoadTime, state RUN, Done=0.
  - Invalid load: PresentTime unchanged, LoadErr=1 for one cycle, state unchanged.
- Arithmetic:
  - Treat the time as T = minutes*60 + seconds, with MAXT = 10^MIN_DIGITS*60 - 1.
  - Up: T' = T + step. Down: T' = T - step.
  - Output is always legal BCD: seconds 00..59, each minute digit 0..9.
  - Step 0 with enable high: no change and no pulses.
- States: RUN, DONE.
  - RUN, up, T+step > MAXT:
    - WRAP_MODE=1: T' = T + step - (MAXT+1), Rollover=1.
    - WRAP_MODE=0: T' = MAXT, go to DONE.
  - RUN, down, step > T:
    - WRAP_MODE=1: T' = T - step + MAXT + 1, Rollover=1.
    - WRAP_MODE=0: T' = 0, go to DONE.
  - Reaching MAXT (up) or 0 (down) exactly without overshoot stays in RUN. DONE is entered only on an overshoot attempt.
  - DONE: enables are ignored and PresentTime holds. Exit only through Reset, a valid Load, or a CountDown value opposite to the saturating direction together with CounterEnable. In that last case the step is applied on the same edge and the state returns to RUN.
- The CountDown value is sampled on each enabled edge. Toggling it mid-run takes effect on the next enabled edge.
- Rollover and LoadErr are never high on the same cycle. Load suppresses stepping, so a Load edge produces no Rollover.

Test Plan:
- MIN_DIGITS=1: Reset for 1 cycle, then enable with step=1 for 60 cycles -> PresentTime=12'h100 (1:00). After 119 cycles -> 12'h159.
- WRAP_MODE=1: Load 9:59, then step=1 up -> PresentTime=12'h000 and Rollover=1 for exactly one cycle. Down with step=3 from 0:01 -> 9:58 with Rollover=1.
- WRAP_MODE=0:
  - Load 9:55, step=7 up -> 9:59 and Done=1. Three further enables leave 9:59.
  - CountDown=1 with step=2 -> 9:57, Done=0.
- Down borrow: Load 1:05, step=10 down -> 0:55. Then step=15 -> 0:40. No Rollover in either step.
- Invalid load: LoadTime=12'h16A, then 12'h160 -> both rejected, LoadErr pulses on each, PresentTime unchanged. Load 12'h159 -> accepted.
- Reset mid-run and priority:
  - Reset asserted while enabled at 3:27 -> 0:00 next edge.
  - Reset with Load both high -> 0:00.
  - Load with enable both high -> the LoadTime value, not LoadTime+step.

Source files
------------

// File: rtl/bcd_time_counter_if.sv
// Control/status bundle between the control FSM, the BCD time counter and the display driver.
interface bcd_time_counter_if #(
    parameter int MIN_DIGITS = 1,
    parameter int TW         = 4 * (MIN_DIGITS + 2)
);
    logic          CounterEnable;
    logic [3:0]    CounterInput;
    logic          CountDown;
    logic          Load;
    logic [TW-1:0] LoadTime;
    logic [TW-1:0] PresentTime;
    logic          Rollover;
    logic          Done;
    logic          LoadErr;

    modport master (
        output CounterEnable, CounterInput, CountDown, Load, LoadTime,
        input  PresentTime, Rollover, Done, LoadErr
    );

    modport slave (
        input  CounterEnable, CounterInput, CountDown, Load, LoadTime,
        output PresentTime, Rollover, Done, LoadErr
    );
endinterface

// File: rtl/bcd_time_counter.sv
// BCD M..M:SS time counter: up/down steps of 0..15 s, validated parallel load,
// wrap or saturate at the limits, with Rollover/Done/LoadErr status.
module bcd_time_counter #(
    parameter int MIN_DIGITS = 1,
    parameter int WRAP_MODE  = 1,
    parameter int TW         = 4 * (MIN_DIGITS + 2)
) (
    input logic               Clk,
    input logic               Reset,
    bcd_time_counter_if.slave bus
);
    localparam int            MW      = 4 * MIN_DIGITS;
    localparam logic [TW-1:0] MAX_BCD = {{MIN_DIGITS{4'h9}}, 8'h59};

    typedef enum logic {RUN, DONE} state_t;

    state_t        state;
    logic          sat_dn;
    logic [TW-1:0] time_q;
    logic          rollover_q;
    logic          loaderr_q;

    logic signed [7:0] sec_p0;
    logic              sec_wrap_p0;
    logic [MW:0]       min_p0;
    logic [TW-1:0]     next_time_p0;
    logic              limit_hit_p0;

    function automatic logic load_valid(input logic [TW-1:0] t);
        logic ok;
        ok = (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
        for (int i = 0; i < MIN_DIGITS; i++)
            if (t[8+4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] sec_to_bcd(input logic [5:0] s);
        return {4'(s / 6'd10), 4'(s % 6'd10)};
    endfunction

    // Ripple a one-minute carry/borrow through the BCD minute digits; MSB is the overflow out.
    function automatic logic [MW:0] min_step(input logic [MW-1:0] m, input logic dn, input logic cin);
        logic [MW-1:0] r;
        logic          c;
        r = m;
        c = cin;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (c) begin
                if (!dn) begin
                    if (m[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = m[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (m[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin
                        r[4*i +: 4] = m[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [TW-1:0] limit_time(input logic dn);
        return dn ? '0 : MAX_BCD;
    endfunction

    always_comb begin
        sec_p0 = signed'({4'b0, time_q[7:4]}) * 8'sd10 + signed'({4'b0, time_q[3:0]});
        if (bus.CountDown) sec_p0 = sec_p0 - signed'({4'b0, bus.CounterInput});
        else               sec_p0 = sec_p0 + signed'({4'b0, bus.CounterInput});
        sec_wrap_p0 = 1'b0;
        if (sec_p0 > 8'sd59) begin
            sec_p0      = sec_p0 - 8'sd60;
            sec_wrap_p0 = 1'b1;
        end else if (sec_p0 < 8'sd0) begin
            sec_p0      = sec_p0 + 8'sd60;
            sec_wrap_p0 = 1'b1;
        end
        min_p0       = min_step(time_q[TW-1:8], bus.CountDown, sec_wrap_p0);
        next_time_p0 = {min_p0[MW-1:0], sec_to_bcd(sec_p0[5:0])};
        limit_hit_p0 = min_p0[MW];
    end

    // Output register stage: Reset > Load > CounterEnable
    always_ff @(posedge Clk) begin
        if (Reset) begin
            time_q     <= '0;
            rollover_q <= 1'b0;
            loaderr_q  <= 1'b0;
            state      <= RUN;
            sat_dn     <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            loaderr_q  <= 1'b0;
            if (bus.Load) begin
                if (load_valid(bus.LoadTime)) begin
                    time_q <= bus.LoadTime;
                    state  <= RUN;
                end else begin
                    loaderr_q <= 1'b1;
                end
            end else if (bus.CounterEnable) begin
                case (state)
                    RUN: begin
                        if (!limit_hit_p0) begin
                            time_q <= next_time_p0;
                        end else if (WRAP_MODE != 0) begin
                            time_q     <= next_time_p0;
                            rollover_q <= 1'b1;
                        end else begin
                            time_q <= limit_time(bus.CountDown);
                            sat_dn <= bus.CountDown;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        // Only stepping away from the saturated limit releases DONE.
                        if (bus.CountDown != sat_dn) begin
                            time_q <= next_time_p0;
                            state  <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign bus.PresentTime = time_q;
    assign bus.Rollover    = rollover_q;
    assign bus.LoadErr     = loaderr_q;
    assign bus.Done        = (state == DONE);
endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: three instances (1-digit wrap, 1-digit saturate, 2-digit wrap)
// share stimulus and are compared each cycle against a seconds-based model.
module tb_bcd_time_counter;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        en;
    logic [3:0]  step;
    logic        dn;
    logic        ld;
    logic [15:0] lt;

    always #5 Clk = ~Clk;

    bcd_time_counter_if #(.MIN_DIGITS(1)) if_w1();
    bcd_time_counter_if #(.MIN_DIGITS(1)) if_s1();
    bcd_time_counter_if #(.MIN_DIGITS(2)) if_w2();

    assign if_w1.CounterEnable = en;
    assign if_w1.CounterInput  = step;
    assign if_w1.CountDown     = dn;
    assign if_w1.Load          = ld;
    assign if_w1.LoadTime      = lt[11:0];
    assign if_s1.CounterEnable = en;
    assign if_s1.CounterInput  = step;
    assign if_s1.CountDown     = dn;
    assign if_s1.Load          = ld;
    assign if_s1.LoadTime      = lt[11:0];
    assign if_w2.CounterEnable = en;
    assign if_w2.CounterInput  = step;
    assign if_w2.CountDown     = dn;
    assign if_w2.Load          = ld;
    assign if_w2.LoadTime      = lt;

    bcd_time_counter #(.MIN_DIGITS(1), .WRAP_MODE(1)) dut_w1 (.Clk(Clk), .Reset(Reset), .bus(if_w1.slave));
    bcd_time_counter #(.MIN_DIGITS(1), .WRAP_MODE(0)) dut_s1 (.Clk(Clk), .Reset(Reset), .bus(if_s1.slave));
    bcd_time_counter #(.MIN_DIGITS(2), .WRAP_MODE(1)) dut_w2 (.Clk(Clk), .Reset(Reset), .bus(if_w2.slave));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model state: time in plain seconds, plus DONE flag and saturating direction.
    int digs[3] = '{1, 1, 2};
    bit wrp[3]  = '{1, 0, 1};
    int mt[3];
    bit mdone[3], msat[3], mroll[3], mlerr[3];
    bit armed = 1'b0;

    function automatic bit bcd_ok(input logic [15:0] b, input int d);
        if (b[3:0] > 4'd9 || b[7:4] > 4'd5 || b[11:8] > 4'd9) return 1'b0;
        if (d == 2 && b[15:12] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_to_t(input logic [15:0] b, input int d);
        int m;
        m = int'(b[11:8]);
        if (d == 2) m += 10 * int'(b[15:12]);
        return m * 60 + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] t_to_bcd(input int t);
        int s, m;
        s = t % 60;
        m = t / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge Clk) begin
        int maxt;
        logic [15:0] ltk;
        for (int k = 0; k < 3; k++) begin
            maxt = (digs[k] == 1 ? 600 : 6000) - 1;
            ltk = (digs[k] == 1) ? {4'h0, lt[11:0]} : lt;
            mroll[k] = 1'b0;
            mlerr[k] = 1'b0;
            if (Reset) begin
                mt[k] = 0;
                mdone[k] = 1'b0;
            end else if (ld) begin
                if (bcd_ok(ltk, digs[k])) begin
                    mt[k] = bcd_to_t(ltk, digs[k]);
                    mdone[k] = 1'b0;
                end else mlerr[k] = 1'b1;
            end else if (en) begin
                if (!mdone[k]) begin
                    if (!dn && mt[k] + int'(step) > maxt) begin
                        if (wrp[k]) begin
                            mt[k] = mt[k] + int'(step) - (maxt + 1);
                            mroll[k] = 1'b1;
                        end else begin
                            mt[k] = maxt; mdone[k] = 1'b1; msat[k] = 1'b0;
                        end
                    end else if (dn && int'(step) > mt[k]) begin
                        if (wrp[k]) begin
                            mt[k] = mt[k] - int'(step) + maxt + 1;
                            mroll[k] = 1'b1;
                        end else begin
                            mt[k] = 0; mdone[k] = 1'b1; msat[k] = 1'b1;
                        end
                    end else mt[k] = dn ? mt[k] - int'(step) : mt[k] + int'(step);
                end else if (dn != msat[k]) begin
                    mt[k] = dn ? mt[k] - int'(step) : mt[k] + int'(step);
                    mdone[k] = 1'b0;
                end
            end
        end
        if (Reset) armed = 1'b1;
    end

    always @(negedge Clk) begin
        if (armed) begin
            chk("w1_time", {4'h0, if_w1.PresentTime}, t_to_bcd(mt[0]));
            chk("w1_roll", 16'(if_w1.Rollover), 16'(mroll[0]));
            chk("w1_done", 16'(if_w1.Done), 16'(mdone[0]));
            chk("w1_lerr", 16'(if_w1.LoadErr), 16'(mlerr[0]));
            chk("s1_time", {4'h0, if_s1.PresentTime}, t_to_bcd(mt[1]));
            chk("s1_roll", 16'(if_s1.Rollover), 16'(mroll[1]));
            chk("s1_done", 16'(if_s1.Done), 16'(mdone[1]));
            chk("s1_lerr", 16'(if_s1.LoadErr), 16'(mlerr[1]));
            chk("w2_time", if_w2.PresentTime, t_to_bcd(mt[2]));
            chk("w2_roll", 16'(if_w2.Rollover), 16'(mroll[2]));
            chk("w2_done", 16'(if_w2.Done), 16'(mdone[2]));
            chk("w2_lerr", 16'(if_w2.LoadErr), 16'(mlerr[2]));
        end
    end

    task automatic drive(input bit e, input logic [3:0] s, input bit d, input bit l,
                         input logic [15:0] t, input bit r);
        en = e; step = s; dn = d; ld = l; lt = t; Reset = r;
        @(negedge Clk);
    endtask

    task automatic load(input logic [15:0] t);
        drive(1'b0, 4'd0, 1'b0, 1'b1, t, 1'b0);
    endtask

    initial begin
        bit rd, rl, re, rdn;
        logic [3:0]  rs;
        logic [15:0] rt;

        drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_time", {4'h0, if_w1.PresentTime}, 16'h0000);
        chk("rst_flags", {13'h0, if_w1.Rollover, if_w1.Done, if_w1.LoadErr}, 16'h0);

        repeat (60) drive(1'b1, 4'd1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("up60", {4'h0, if_w1.PresentTime}, 16'h0100);
        chk("model_up60", t_to_bcd(mt[0]), 16'h0100);
        repeat (59) drive(1'b1, 4'd1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("up119", {4'h0, if_w1.PresentTime}, 16'h0159);

        load(16'h0959);
        drive(1'b1, 4'd1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap_up_time", {4'h0, if_w1.PresentTime}, 16'h0000);
        chk("wrap_up_roll", 16'(if_w1.Rollover), 16'h1);
        chk("sat_up_done", {3'h0, if_s1.Done, if_s1.PresentTime}, 16'h1959);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("roll_one_cycle", 16'(if_w1.Rollover), 16'h0);

        load(16'h0001);
        drive(1'b1, 4'd3, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("wrap_dn_time", {4'h0, if_w1.PresentTime}, 16'h0958);
        chk("wrap_dn_roll", 16'(if_w1.Rollover), 16'h1);

        load(16'h0955);
        drive(1'b1, 4'd7, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("sat_time", {4'h0, if_s1.PresentTime}, 16'h0959);
        chk("sat_done", 16'(if_s1.Done), 16'h1);
        repeat (3) drive(1'b1, 4'd7, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("sat_hold", {3'h0, if_s1.Done, if_s1.PresentTime}, 16'h1959);
        drive(1'b1, 4'd2, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("sat_exit", {3'h0, if_s1.Done, if_s1.PresentTime}, 16'h0957);
        chk("model_sat_exit", t_to_bcd(mt[1]), 16'h0957);

        load(16'h0105);
        drive(1'b1, 4'd10, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("borrow1", {3'h0, if_w1.Rollover, if_w1.PresentTime}, 16'h0055);
        drive(1'b1, 4'd15, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("borrow2", {3'h0, if_w1.Rollover, if_w1.PresentTime}, 16'h0040);

        load(16'h016A);
        chk("bad_load_a", {3'h0, if_w1.LoadErr, if_w1.PresentTime}, 16'h1040);
        load(16'h0160);
        chk("bad_load_b", {3'h0, if_w1.LoadErr, if_w1.PresentTime}, 16'h1040);
        load(16'h0159);
        chk("good_load", {3'h0, if_w1.LoadErr, if_w1.PresentTime}, 16'h0159);

        load(16'h0327);
        drive(1'b1, 4'd1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_mid_run", {4'h0, if_w1.PresentTime}, 16'h0000);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 16'h0327, 1'b1);
        chk("rst_over_load", {4'h0, if_w1.PresentTime}, 16'h0000);
        drive(1'b1, 4'd5, 1'b0, 1'b1, 16'h0300, 1'b0);
        chk("load_over_en", {4'h0, if_w1.PresentTime}, 16'h0300);

        rdn = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 199) == 0);
            rl = ($urandom_range(0, 19) == 0);
            re = ($urandom_range(0, 3) != 0);
            rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) rdn = ~rdn;
            case ($urandom_range(0, 3))
                0: rt = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                1: rt = {8'h99, 4'h5, 4'($urandom_range(0, 9))};
                2: rt = {12'h000, 4'($urandom_range(0, 9))};
                default: rt = 16'($urandom);
            endcase
            drive(re, rs, rdn, rl, rt, rd);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
